apb_requester_arbiter: RTL and testbench

- Single APB requester (bus master) that shares one APB bus between NUM_REQ local requesters.
- Arbitration is round-robin. Each granted transfer is sequenced through standard APB SETUP and ACCESS phases.
- Read data and error status are returned to the winning requester.
- Sits between on-chip client logic and apb_peripheral instances, and bounds every transfer with a PREADY timeout.

---
 rtl/apb_pkg.sv | 19 +
 rtl/apb_if.sv | 24 ++
 rtl/apb_requester_arbiter_rr_arbiter.sv | 39 +++
 rtl/apb_requester_arbiter.sv | 131 +++++++++++++
 tb/tb_apb_requester_arbiter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB widths, arbiter state encoding and sizing helpers
package apb_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int ALIGNBITS  = $clog2(DATA_WIDTH / 8);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } arb_state;

  // Counter width able to hold TIMEOUT-1, never narrower than one bit.
  function automatic int timeout_w(input int t);
    return (t <= 1) ? 1 : $clog2(t);
  endfunction

endpackage

// File: rtl/apb_if.sv
// rtl/apb_if.sv - APB bus bundle with requester and completer views
interface apb_if;
  import apb_pkg::*;

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport requester (
    output psel, penable, paddr, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport completer (
    input  psel, penable, paddr, pwrite, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_requester_arbiter_rr_arbiter.sv
// rtl/apb_requester_arbiter_rr_arbiter.sv - combinational round-robin picker
// Chooses the first unmasked request at or after ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  input  logic [NUM_REQ-1:0] mask,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     idx,
  output logic               any
);

  logic [NUM_REQ-1:0] eligible;

  assign eligible = req & ~mask;

  always_comb begin
    int             slot;
    logic [IDW-1:0] j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    slot  = 0;
    j     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      slot = int'(ptr) + i;
      if (slot >= NUM_REQ) slot = slot - NUM_REQ;
      j = IDW'(slot);
      if (!any && eligible[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/apb_requester_arbiter.sv
// rtl/apb_requester_arbiter.sv - round-robin APB requester shared by NUM_REQ clients
// Each grant runs SETUP then ACCESS; completion is bounded by a pready timeout.
module apb_requester_arbiter
  import apb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int TIMEOUT = 16,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                                pclk,
  input  logic                                presetn,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0]                  req_write,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_wdata,
  output logic                                resp_valid,
  output logic [IDW-1:0]                      resp_id,
  output logic [DATA_WIDTH-1:0]               resp_rdata,
  output logic                                resp_err,
  output logic                                resp_timeout,
  apb_if.requester                            apb
);

  localparam int TW = timeout_w(TIMEOUT);

  arb_state              state;
  logic [IDW-1:0]        ptr;
  logic [IDW-1:0]        winner;
  logic [TW-1:0]         cnt;

  logic [NUM_REQ-1:0]    mask;
  logic [NUM_REQ-1:0]    grant;
  logic [IDW-1:0]        sel_idx;
  logic                  sel_any;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_write;
  logic                  done;
  logic [IDW-1:0]        next_ptr;

  // The requester being answered this cycle may still hold valid; keep it out.
  always_comb begin
    mask = '0;
    if (resp_valid) mask[resp_id] = 1'b1;
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .mask  (mask),
    .grant (grant),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr  = req_addr[i];
        sel_wdata = req_wdata[i];
        sel_write = req_write[i];
      end
    end
  end

  assign done     = apb.pready || (cnt == TW'(TIMEOUT - 1));
  assign next_ptr = (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state        <= IDLE;
      ptr          <= '0;
      winner       <= '0;
      cnt          <= '0;
      apb.psel     <= 1'b0;
      apb.penable  <= 1'b0;
      apb.pwrite   <= 1'b0;
      apb.paddr    <= '0;
      apb.pwdata   <= '0;
      resp_valid   <= 1'b0;
      resp_id      <= '0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      resp_timeout <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_any) begin
            state      <= SETUP;
            winner     <= sel_idx;
            apb.psel   <= 1'b1;
            apb.paddr  <= sel_addr;
            apb.pwrite <= sel_write;
            apb.pwdata <= sel_wdata;
          end
        end
        SETUP: begin
          state       <= ACCESS;
          apb.penable <= 1'b1;
          cnt         <= '0;
        end
        ACCESS: begin
          if (done) begin
            state        <= IDLE;
            apb.psel     <= 1'b0;
            apb.penable  <= 1'b0;
            ptr          <= next_ptr;
            resp_valid   <= 1'b1;
            resp_id      <= winner;
            resp_timeout <= !apb.pready;
            resp_err     <= !apb.pready || apb.pslverr;
            // Read data is only trusted on a clean, non-error read completion.
            resp_rdata   <= (apb.pready && !apb.pslverr && !apb.pwrite) ? apb.prdata : '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          apb.psel    <= 1'b0;
          apb.penable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_requester_arbiter.sv
// tb/tb_apb_requester_arbiter.sv - self-checking bench for apb_requester_arbiter
module tb_apb_requester_arbiter;
  import apb_pkg::*;

  localparam int NR  = 4;
  localparam int TMO = 16;

  logic                           pclk = 1'b0;
  logic                           presetn = 1'b0;
  logic [NR-1:0]                  req_valid = '0;
  logic [NR-1:0]                  req_write = '0;
  logic [NR-1:0][ADDR_WIDTH-1:0]  req_addr = '0;
  logic [NR-1:0][DATA_WIDTH-1:0]  req_wdata = '0;
  logic                           resp_valid;
  logic [1:0]                     resp_id;
  logic [DATA_WIDTH-1:0]          resp_rdata;
  logic                           resp_err;
  logic                           resp_timeout;

  apb_if apb_bus ();

  bit never_ready = 1'b0;
  int wcnt;
  int vectors = 0;
  int miscompares = 0;
  int mptr = 0;

  bit                    pend [NR];
  bit                    pw   [NR];
  logic [ADDR_WIDTH-1:0] pa   [NR];

  typedef struct {
    int                    id;
    bit                    w;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    bit                    nr;
    logic [DATA_WIDTH-1:0] rdata;
    bit                    err;
    bit                    tmo;
    int                    lat;
  } vec_t;

  vec_t vecs [8];

  always #5 pclk = ~pclk;

  apb_requester_arbiter #(.NUM_REQ(NR), .TIMEOUT(TMO)) dut (
    .pclk         (pclk),
    .presetn      (presetn),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_id      (resp_id),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .resp_timeout (resp_timeout),
    .apb          (apb_bus)
  );

  // Peripheral: wait states from paddr[5:4], pslverr on misaligned address.
  function automatic logic [31:0] periph_data(input logic [31:0] a);
    if (a == 32'h8) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  always @(posedge pclk or negedge presetn) begin
    if (!presetn) wcnt <= 0;
    else if (apb_bus.psel && apb_bus.penable && !apb_bus.pready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  assign apb_bus.pready  = apb_bus.psel && apb_bus.penable && !never_ready &&
                           (wcnt >= int'(apb_bus.paddr[5:4]));
  assign apb_bus.pslverr = apb_bus.pready && (apb_bus.paddr[1:0] != 2'b00);
  assign apb_bus.prdata  = periph_data(apb_bus.paddr);

  function automatic logic [31:0] exp_rdata(input bit w, input logic [31:0] a);
    if (w || a[1:0] != 2'b00) return 32'h0;
    return periph_data(a);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_psel"},    64'(apb_bus.psel), 0);
    chk({t, "_penable"}, 64'(apb_bus.penable), 0);
    chk({t, "_pwrite"},  64'(apb_bus.pwrite), 0);
    chk({t, "_paddr"},   64'(apb_bus.paddr), 0);
    chk({t, "_pwdata"},  64'(apb_bus.pwdata), 0);
    chk({t, "_rvalid"},  64'(resp_valid), 0);
    chk({t, "_rid"},     64'(resp_id), 0);
    chk({t, "_rdata"},   64'(resp_rdata), 0);
    chk({t, "_rerr"},    64'(resp_err), 0);
    chk({t, "_rtmo"},    64'(resp_timeout), 0);
  endtask

  task automatic wait_resp(input int bound, output int lat, output bit seen);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < bound) begin
      @(negedge pclk);
      lat++;
      if (resp_valid) seen = 1'b1;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL resp_wait: no resp_valid within %0d cycles", bound);
    end
  endtask

  // One isolated transfer; called at a negedge, returns at a negedge.
  task automatic single(input vec_t v, input int n);
    int    lat, np, ne;
    bit    seen, stable;
    string s;
    s = $sformatf("v%0d", n);
    never_ready       = v.nr;
    req_valid         = '0;
    req_valid[v.id]   = 1'b1;
    req_write[v.id]   = v.w;
    req_addr[v.id]    = v.addr;
    req_wdata[v.id]   = v.wdata;
    lat = 0; np = 0; ne = 0; seen = 1'b0; stable = 1'b1;
    while (!seen && lat < 60) begin
      @(negedge pclk);
      lat++;
      if (apb_bus.psel) begin
        np++;
        if (apb_bus.paddr !== v.addr || apb_bus.pwrite !== v.w || apb_bus.pwdata !== v.wdata)
          stable = 1'b0;
      end
      if (apb_bus.penable) ne++;
      if (resp_valid) seen = 1'b1;
    end
    req_valid[v.id] = 1'b0;
    chk({s, "_lat"},     64'(lat), 64'(v.lat));
    chk({s, "_id"},      64'(resp_id), 64'(v.id));
    chk({s, "_rdata"},   64'(resp_rdata), 64'(v.rdata));
    chk({s, "_err"},     64'(resp_err), 64'(v.err));
    chk({s, "_tmo"},     64'(resp_timeout), 64'(v.tmo));
    chk({s, "_psel_n"},  64'(np), 64'(v.lat - 1));
    chk({s, "_pen_n"},   64'(ne), 64'(v.lat - 2));
    chk({s, "_stable"},  64'(stable), 1);
    mptr = (v.id + 1) % NR;
    never_ready = 1'b0;
    @(negedge pclk);
    chk({s, "_pulse"},   64'(resp_valid), 0);
  endtask

  task automatic gen(input int i);
    logic [31:0] a;
    a = $urandom & 32'h0000_FFFF;
    if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
    pend[i]      = 1'b1;
    pw[i]        = 1'($urandom_range(0, 1));
    pa[i]        = a;
    req_valid[i] = 1'b1;
    req_write[i] = pw[i];
    req_addr[i]  = a;
    req_wdata[i] = $urandom;
  endtask

  initial begin
    int  lat;
    bit  seen;
    int  cnts [NR];
    int  e, extra, others;

    vecs[0] = '{2, 1'b0, 32'h08, 32'h1111_1111, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 3};
    vecs[1] = '{1, 1'b1, 32'h30, 32'h1234_5678, 1'b0, 32'h0,        1'b0, 1'b0, 6};
    vecs[2] = '{3, 1'b0, 32'h05, 32'h0,         1'b0, 32'h0,        1'b1, 1'b0, 3};
    vecs[3] = '{0, 1'b0, 32'h14, 32'hAAAA_0000, 1'b0, 32'h0014FFEB, 1'b0, 1'b0, 4};
    vecs[4] = '{3, 1'b1, 32'h22, 32'h5555_AAAA, 1'b0, 32'h0,        1'b1, 1'b0, 5};
    vecs[5] = '{1, 1'b0, 32'h2C, 32'h0,         1'b0, 32'h002CFFD3, 1'b0, 1'b0, 5};
    vecs[6] = '{0, 1'b0, 32'h40, 32'h0,         1'b1, 32'h0,        1'b1, 1'b1, 2 + TMO};
    vecs[7] = '{2, 1'b0, 32'h3C, 32'h0,         1'b0, 32'h003CFFC3, 1'b0, 1'b0, 6};

    repeat (3) @(negedge pclk);
    chk_reset("rst");
    presetn = 1'b1;

    for (int n = 0; n < 8; n++) single(vecs[n], n);

    // Reset pulse in the middle of an ACCESS phase, then the request restarts.
    req_valid[3] = 1'b1; req_write[3] = 1'b0;
    req_addr[3]  = 32'h30; req_wdata[3] = 32'hCAFE_0000;
    lat = 0;
    while (!apb_bus.penable && lat < 20) begin @(negedge pclk); lat++; end
    chk("mid_reach_access", 64'(apb_bus.penable), 1);
    #2 presetn = 1'b0;
    #1 chk_reset("mid");
    mptr = 0;
    @(negedge pclk);
    chk("mid_no_resp", 64'(resp_valid), 0);
    presetn = 1'b1;
    wait_resp(40, lat, seen);
    chk("mid_lat",   64'(lat), 6);
    chk("mid_id",    64'(resp_id), 3);
    chk("mid_rdata", 64'(resp_rdata), 64'(32'h0030FFCF));
    chk("mid_err",   64'(resp_err), 0);
    req_valid[3] = 1'b0;
    mptr = 0;
    @(negedge pclk);

    // All four requesters continuously valid for eight transfers.
    for (int i = 0; i < NR; i++) begin
      cnts[i] = 0;
      req_valid[i] = 1'b1; req_write[i] = 1'b0;
      req_addr[i]  = 32'h100 + 32'(4 * i);
      req_wdata[i] = 32'(i);
    end
    for (int t = 0; t < 8; t++) begin
      wait_resp(30, lat, seen);
      chk($sformatf("rr%0d_id", t),    64'(resp_id), 64'(mptr));
      chk($sformatf("rr%0d_gap", t),   64'(lat), 3);
      chk($sformatf("rr%0d_rdata", t), 64'(resp_rdata), 64'(periph_data(32'h100 + 32'(4 * mptr))));
      cnts[resp_id]++;
      mptr = (mptr + 1) % NR;
      if (t == 7) req_valid = '0;
    end
    for (int i = 0; i < NR; i++) chk($sformatf("rr_count%0d", i), 64'(cnts[i]), 2);
    repeat (2) @(negedge pclk);
    req_valid = '1;
    wait_resp(30, lat, seen);
    chk("rr_ptr_wrap_id", 64'(resp_id), 0);
    req_valid = '0;
    mptr = 1;

    // Randomized bursts against the round-robin reference model.
    for (int i = 0; i < NR; i++) pend[i] = 1'b0;
    extra = 0;
    for (int n = 0; n < 80; n++) begin
      others = 0;
      for (int i = 0; i < NR; i++) others += int'(pend[i]);
      if (others == 0) begin
        repeat (2) @(negedge pclk);
        e = $urandom_range(1, 15);
        for (int i = 0; i < NR; i++) if (e[i]) gen(i);
        extra = 0;
      end
      e = -1;
      for (int k = 0; k < NR; k++) begin
        int c;
        c = (mptr + k) % NR;
        if (e < 0 && pend[c]) e = c;
      end
      wait_resp(60, lat, seen);
      chk($sformatf("rnd%0d_id", n),    64'(resp_id), 64'(e));
      chk($sformatf("rnd%0d_gap", n),   64'(lat), 64'(3 + int'(pa[e][5:4]) + extra));
      chk($sformatf("rnd%0d_rdata", n), 64'(resp_rdata), 64'(exp_rdata(pw[e], pa[e])));
      chk($sformatf("rnd%0d_err", n),   64'(resp_err), 64'(pa[e][1:0] != 2'b00));
      chk($sformatf("rnd%0d_tmo", n),   64'(resp_timeout), 0);
      pend[e] = 1'b0;
      req_valid[e] = 1'b0;
      mptr = (e + 1) % NR;
      extra = 0;
      if ($urandom_range(0, 2) == 0) begin
        others = 0;
        for (int i = 0; i < NR; i++) others += int'(pend[i]);
        gen(e);
        if (others == 0) extra = 1;
      end
    end
    req_valid = '0;
    repeat (2) @(negedge pclk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
